// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-style call scheduler that commands a NUM_FLOORS elevator car.
// Optional emergency-stop input is enabled by defining ESTOP_EN.
module elevator_scheduler #(
  parameter int NUM_FLOORS       = 5,
  parameter int FLOOR_W          = 3,
  parameter int DOOR_HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_door,
`ifdef ESTOP_EN
  input  logic                  estop,
`endif
  output logic [1:0]            updown,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DOOR_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(DOOR_HOLD_CYCLES - 1);
  localparam logic [1:0] UD_STOP = 2'b00;
  localparam logic [1:0] UD_UP   = 2'b01;
  localparam logic [1:0] UD_DOWN = 2'b10;

  typedef enum logic [2:0] {IDLE, MOVE, OPEN_WAIT, HOLD, CLOSE_WAIT} state_t;

  state_t                state;
  logic [CNT_W-1:0]      hold_cnt;
  logic [NUM_FLOORS-1:0] floor_hot;
  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;
  logic                  floor_valid;
  logic                  here_pend;
  logic                  here_call;
  logic                  ahead;
  logic                  behind;

  // Floor masks relative to the car: the car's own floor, floors above it, floors below it.
  always_comb begin
    floor_hot = '0;
    above     = '0;
    below     = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      floor_hot[i] = (FLOOR_W'(i + 1) == car_floor);
      above[i]     = (FLOOR_W'(i + 1) > car_floor);
      below[i]     = (FLOOR_W'(i + 1) < car_floor);
    end
  end

  assign floor_valid = (car_floor != '0) && (car_floor <= FLOOR_W'(NUM_FLOORS));
  assign here_pend   = |(pending & floor_hot);
  assign here_call   = |(call_req & floor_hot);
  assign ahead       = dir_up ? |(pending & above) : |(pending & below);
  assign behind      = dir_up ? |(pending & below) : |(pending & above);
  assign busy        = (state != IDLE) || (pending != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      updown    <= UD_STOP;
      door_open <= 1'b0;
      pending   <= '0;
      dir_up    <= 1'b1;
      hold_cnt  <= '0;
    end
`ifdef ESTOP_EN
    else if (estop) begin
      state     <= IDLE;
      updown    <= UD_STOP;
      door_open <= 1'b0;
      pending   <= '0;
    end
`endif
    else if (!floor_valid) begin
      // Unknown car position: freeze the sequence but keep collecting calls.
      updown    <= UD_STOP;
      door_open <= 1'b0;
      pending   <= pending | call_req;
    end else begin
      pending <= pending | call_req;
      case (state)
        IDLE: begin
          updown    <= UD_STOP;
          door_open <= 1'b0;
          if (here_pend) begin
            state     <= OPEN_WAIT;
            door_open <= 1'b1;
          end else if (!car_door && ahead) begin
            state  <= MOVE;
            updown <= dir_up ? UD_UP : UD_DOWN;
          end else if (!car_door && behind) begin
            state  <= MOVE;
            dir_up <= !dir_up;
            updown <= dir_up ? UD_DOWN : UD_UP;
          end
        end
        MOVE: begin
          door_open <= 1'b0;
          if (here_pend) begin
            state     <= OPEN_WAIT;
            updown    <= UD_STOP;
            door_open <= 1'b1;
          end else if (car_door || (dir_up && car_floor == FLOOR_W'(NUM_FLOORS)) ||
                       (!dir_up && car_floor == FLOOR_W'(1))) begin
            state  <= IDLE;
            updown <= UD_STOP;
          end else begin
            updown <= dir_up ? UD_UP : UD_DOWN;
          end
        end
        OPEN_WAIT: begin
          updown    <= UD_STOP;
          door_open <= 1'b1;
          if (car_door) begin
            state    <= HOLD;
            pending  <= (pending | call_req) & ~floor_hot;
            hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          // The door is already open here, so a same-floor call only extends the hold.
          updown    <= UD_STOP;
          door_open <= 1'b1;
          pending   <= pending | (call_req & ~floor_hot);
          if (here_call) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state     <= CLOSE_WAIT;
            door_open <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        CLOSE_WAIT: begin
          updown    <= UD_STOP;
          door_open <= 1'b0;
          if (here_call) begin
            state     <= OPEN_WAIT;
            door_open <= 1'b1;
          end else if (!car_door) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          updown    <= UD_STOP;
          door_open <= 1'b0;
        end
      endcase
    end
  end

endmodule
